// File: rtl/nand_target_responder_if.sv
// Device-side NAND target bus: the controller drives the strobes and IO_IN (master),
// the emulated flash target returns IO_OUT/IO_OE/RB (slave).
interface nand_target_responder_if;
    logic       nCE;
    logic       CLE;
    logic       ALE;
    logic       nWE;
    logic       nRE;
    logic       nWP;
    logic [7:0] IO_IN;
    logic [7:0] IO_OUT;
    logic       IO_OE;
    logic       RB;

    modport master (
        output nCE, CLE, ALE, nWE, nRE, nWP, IO_IN,
        input  IO_OUT, IO_OE, RB
    );

    modport slave (
        input  nCE, CLE, ALE, nWE, nRE, nWP, IO_IN,
        output IO_OUT, IO_OE, RB
    );
endinterface

// File: rtl/nand_target_responder.sv
// In-fabric NAND flash target: decodes command/address/data cycles on nWE, serves page,
// ID and status bytes on nRE, and holds RB low for programmable busy times.
module nand_target_responder #(
    parameter int unsigned PAGE_BYTES = 16,
    parameter int unsigned PAGES      = 4,
    parameter int unsigned T_R        = 20,
    parameter int unsigned T_PROG     = 40,
    parameter int unsigned T_RST      = 8,
    parameter logic [39:0] ID_BYTES   = 40'h2C_38_00_26_85
) (
    input  logic                   SYSCLK,
    input  logic                   SYSRESET,
    nand_target_responder_if.slave bus
);
    localparam int unsigned CW = $clog2(PAGE_BYTES);
    localparam int unsigned RW = $clog2(PAGES);

    typedef logic [CW-1:0] col_t;
    typedef logic [RW-1:0] row_t;
    typedef logic [7:0] page_t [PAGE_BYTES];

    typedef enum logic [2:0] {
        StIdle, StAddr, StWaitConf, StBusy, StDout, StDin, StIdOut, StStOut
    } state_e;

    typedef enum logic [1:0] {OpRead, OpProg, OpRst} op_e;

    state_e      state_q, state_d, prev_q, prev_d, done_state, cur_state;
    op_e         op_q, op_d;
    logic        busy_q, busy_d, fail_q, fail_d, prog_ok_q, prog_ok_d;
    logic        nwe_q, nwe_d, nre_q, nre_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [2:0]  addr_cnt_q, addr_cnt_d, id_idx_q, id_idx_d;
    logic [31:0] addr_q, addr_d;
    col_t        col_q, col_d;
    row_t        row_q, row_d;
    page_t       page_q, page_d;
    page_t       mem_q [PAGES];

    logic        we_rise, re_rise, is_cmd, is_addr, is_data, mem_we;
    logic        out_state;
    logic [7:0]  io_out;

    assign we_rise = bus.nWE & ~nwe_q & ~bus.nCE;
    assign re_rise = bus.nRE & ~nre_q & ~bus.nCE;
    assign is_cmd  = we_rise & bus.CLE & ~bus.ALE;
    assign is_addr = we_rise & bus.ALE & ~bus.CLE;
    assign is_data = we_rise & ~bus.CLE & ~bus.ALE;

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        op_d       = op_q;
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        fail_d     = fail_q;
        prog_ok_d  = prog_ok_q;
        cmd_d      = cmd_q;
        addr_cnt_d = addr_cnt_q;
        id_idx_d   = id_idx_q;
        addr_d     = addr_q;
        col_d      = col_q;
        row_d      = row_q;
        page_d     = page_q;
        mem_we     = 1'b0;
        nwe_d      = bus.nWE;
        nre_d      = bus.nRE;
        done_state = (op_q == OpRead) ? StDout : StIdle;
        cur_state  = (state_q == StStOut) ? prev_q : state_q;

        if (re_rise) begin
            if (state_q == StDout) begin
                col_d = col_q + 1'b1;
            end else if (state_q == StIdOut) begin
                id_idx_d = (id_idx_q == 3'd4) ? 3'd0 : id_idx_q + 3'd1;
            end
        end

        // The countdown keeps running while status is being read out.
        if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                if (op_q == OpRead) page_d = mem_q[row_q];
                mem_we = (op_q == OpProg) && prog_ok_q;
                if (state_q == StBusy) state_d = done_state;
                else                   prev_d  = done_state;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end

        if (is_cmd) begin
            if (bus.IO_IN == 8'hFF) begin
                state_d = StBusy;
                busy_d  = 1'b1;
                cnt_d   = 16'(T_RST - 1);
                op_d    = OpRst;
                fail_d  = 1'b0;
                mem_we  = 1'b0;
            end else if (bus.IO_IN == 8'h70) begin
                if (state_q != StStOut) prev_d = state_d;
                state_d = StStOut;
            end else if (!busy_q) begin
                state_d = StIdle;
                case (bus.IO_IN)
                    8'h00, 8'h80, 8'h90: begin
                        state_d    = StAddr;
                        cmd_d      = bus.IO_IN;
                        addr_cnt_d = '0;
                        if (bus.IO_IN == 8'h80) page_d = '{default: 8'hFF};
                    end
                    8'h30: begin
                        if (cur_state == StWaitConf) begin
                            state_d = StBusy;
                            busy_d  = 1'b1;
                            cnt_d   = 16'(T_R - 1);
                            op_d    = OpRead;
                        end
                    end
                    8'h10: begin
                        if (cur_state == StDin) begin
                            state_d   = StBusy;
                            busy_d    = 1'b1;
                            cnt_d     = 16'(T_PROG - 1);
                            op_d      = OpProg;
                            prog_ok_d = bus.nWP;
                            fail_d    = ~bus.nWP;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (is_addr && state_q == StAddr) begin
            if (cmd_q == 8'h90) begin
                state_d  = StIdOut;
                id_idx_d = '0;
            end else if (addr_cnt_q < 3'd4) begin
                addr_d[{addr_cnt_q[1:0], 3'b000} +: 8] = bus.IO_IN;
                addr_cnt_d = addr_cnt_q + 3'd1;
            end else begin
                // Truncation implements the modulo for power-of-two geometry.
                col_d      = col_t'(addr_q[15:0]);
                row_d      = row_t'({bus.IO_IN, addr_q[31:16]});
                addr_cnt_d = addr_cnt_q + 3'd1;
                state_d    = (cmd_q == 8'h80) ? StDin : StWaitConf;
            end
        end else if (is_data && state_q == StDin) begin
            page_d[col_q] = bus.IO_IN;
            col_d         = col_q + 1'b1;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            state_q    <= StIdle;
            prev_q     <= StIdle;
            op_q       <= OpRst;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            fail_q     <= 1'b0;
            prog_ok_q  <= 1'b0;
            nwe_q      <= 1'b1;
            nre_q      <= 1'b1;
            cmd_q      <= '0;
            addr_cnt_q <= '0;
            id_idx_q   <= '0;
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            page_q     <= '{default: 8'hFF};
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            op_q       <= op_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            prog_ok_q  <= prog_ok_d;
            nwe_q      <= nwe_d;
            nre_q      <= nre_d;
            cmd_q      <= cmd_d;
            addr_cnt_q <= addr_cnt_d;
            id_idx_q   <= id_idx_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            page_q     <= page_d;
        end
    end

    // Array survives reset; only a completed, unprotected program writes it.
    always_ff @(posedge SYSCLK) begin
        if (mem_we && !SYSRESET) mem_q[row_q] <= page_q;
    end

    always_comb begin
        io_out = 8'h00;
        case (state_q)
            StDout:  io_out = page_q[col_q];
            StIdOut: begin
                case (id_idx_q)
                    3'd0:    io_out = ID_BYTES[39:32];
                    3'd1:    io_out = ID_BYTES[31:24];
                    3'd2:    io_out = ID_BYTES[23:16];
                    3'd3:    io_out = ID_BYTES[15:8];
                    default: io_out = ID_BYTES[7:0];
                endcase
            end
            StStOut: io_out = {bus.nWP, ~busy_q, ~busy_q, 4'b0000, fail_q};
            default: ;
        endcase
    end

    assign out_state  = state_q inside {StDout, StIdOut, StStOut};
    assign bus.IO_OE  = ~bus.nCE & ~bus.nRE & out_state;
    assign bus.IO_OUT = io_out;
    assign bus.RB     = ~busy_q;
endmodule

// File: doc/nand_target_responder.md
Name: nand_target_responder

Overview:
Synthesizable NAND flash target that emulates the device side of the MT29F8G08ABACAWP flash controller's target bus (nCE/CLE/ALE/nWE/nRE/nWP/RB plus 8-bit IO).
- Latches commands, addresses and data on nWE strobes.
- Returns read data, ID and status on nRE strobes.
- Drives RB busy for programmable times.
- Holds a small page array.
Used as the in-fabric loopback target for controller bring-up and regression.

Parameters:
PAGE_BYTES, 16, bytes per page; power of two.
PAGES, 4, number of pages in the array; power of two.
T_R, 20, SYSCLK cycles RB is low for a page read.
T_PROG, 40, SYSCLK cycles RB is low for a page program.
T_RST, 8, SYSCLK cycles RB is low after a 0xFF reset command.
ID_BYTES, 40'h2C_38_00_26_85, Read ID sequence; MS byte is sent first.

Ports:
SYSCLK  in  1  system clock; all logic on rising edge.
SYSRESET  in  1  synchronous, active-high reset.
nCE  in  1  chip enable, active low.
CLE  in  1  command latch enable.
ALE  in  1  address latch enable.
nWE  in  1  write strobe; bus byte latched on the rising edge.
nRE  in  1  read strobe; output byte advances on the rising edge.
nWP  in  1  write protect, active low.
IO_IN  in  8  byte from controller.
IO_OUT  out  8  byte to controller.
IO_OE  out  1  IO_OUT drive enable.
RB  out  1  ready(1)/busy(0).

Behaviour:
- Reset: state IDLE, RB=1, IO_OE=0, IO_OUT=8'h00, FAIL=0, address counter=0.
  - Array contents are not affected by reset.
  - Page register is set to all 8'hFF.
- Strobe detection:
  - nWE and nRE are registered once.
  - we_rise = nWE & ~nWE_q; re_rise = nRE & ~nRE_q.
  - Both are qualified by nCE=0. IO_IN is sampled in the same cycle as we_rise.
  - With nCE=1: all strobes are ignored, IO_OE=0, and the state is held (a BUSY countdown continues).
- Cycle decode on we_rise:
  - CLE=1, ALE=0: command.
  - ALE=1, CLE=0: address.
  - CLE=0, ALE=0: data.
  - CLE=1, ALE=1: ignored.
- States: IDLE, ADDR, WAIT_CONF, BUSY, DOUT, DIN, ID_OUT, ST_OUT.
- Commands:
  - 0xFF: accepted in any state, including BUSY. Aborts the current operation, RB=0 for T_RST cycles, then IDLE. FAIL is cleared.
  - 0x70: enter ST_OUT, which outputs status {nWP, RB, RB, 4'b0, FAIL}. The previous state is restored on the next command. Legal while BUSY (status shows bits 6 and 5 = 0); all other commands are ignored while BUSY.
  - 0x90: expects 1 address byte (any value), then ID_OUT. Outputs ID_BYTES bytes MS-first and wraps after the 5th byte.
  - 0x00: ADDR state, expects 5 address bytes.
    - col = {a1,a0} mod PAGE_BYTES; row = {a4,a3,a2} mod PAGES.
    - After the 5th byte, WAIT_CONF; 0x30 then BUSY for T_R cycles.
    - During BUSY the page register is loaded from array[row]. Then DOUT starting at col.
  - 0x80: page register filled with 8'hFF, 5 address bytes, then DIN.
    - Each data byte is written to reg[col] and col increments.
    - 0x10: if nWP=1, BUSY T_PROG, array[row] = register, FAIL=0. If nWP=0, BUSY T_PROG, array untouched, FAIL=1.
  - Any other command, or a confirm arriving before 5 address bytes: return to IDLE, nothing written.
- Output:
  - IO_OE = ~nCE & ~nRE & (state in DOUT/ID_OUT/ST_OUT).
  - IO_OUT holds the current byte whenever in an output state.
  - re_rise advances col (DOUT) or the ID index.
  - col wraps from PAGE_BYTES-1 to 0 in both DOUT and DIN.
- Extra address bytes beyond 5 are ignored. Data cycles outside DIN are ignored.
- RB falls in the cycle after the confirm we_rise. It rises exactly T_x cycles later.
- SYSRESET mid-BUSY: immediate IDLE, RB=1, no array write.

Test Plan:
- Reset, then 0x70 → IO_OUT=8'hE0 with nWP=1 (bits 7/6/5 set, FAIL=0); IO_OE=1 only while nRE=0.
- 0x90, addr 0x00, 6 nRE pulses → bytes 2C,38,00,26,85,2C.
- 0x80, addr 03,00,01,00,00, data A0..A3, 0x10, nWP=1 → RB low exactly 40 cycles. Then 0x00, same addr, 0x30 → RB low 20 cycles. Reads give A0,A1,A2,A3,FF.
- Program to page 2 with col 14, 4 bytes 11..14 → page 2 bytes 14,15,0,1 = 11,12,13,14 (wrap check).
- nWP=0 program of page 0 with 0x55 → status 8'h61 (bit7=0, ready, FAIL=1); a later read of page 0 returns the prior contents.
- 0xFF issued during a T_PROG busy → RB stays low for T_RST=8 cycles, then high; the array page is unchanged. SYSRESET mid-read → RB=1, IO_OE=0 next cycle.
